sd_bus_arbiter: RTL

Schedules the single SD-card SPI bus between the initialisation engine and the sector read/write engines. It holds the bus for the init engine until `init_done`, then serialises write and read requests from two requesters with round-robin fairness. It issues one-cycle start pulses with latched sector addresses to the engines and muxes their `cs`/`mosi`/`clk` onto the card pins. It sits between the SD engines and the application-side FIFO/DDR logic.

---
 rtl/sd_bus_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_bus_arbiter.sv
// sd_bus_arbiter: shares the SD-card SPI pins between the init engine and the sector write/read engines.
// Define SD_ARB_TIMEOUT_EN to enable busy-handshake timeout supervision (wr_err/rd_err pulses).
module sd_bus_arbiter #(
  parameter int unsigned GAP_CYC  = 16,
  parameter logic [23:0] START_TO = 24'd400,
  parameter logic [23:0] BUSY_TO  = 24'd10_000_000
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        init_cs,
  input  logic        init_mosi,
  input  logic        init_clk,
  input  logic        wr_cs,
  input  logic        wr_mosi,
  input  logic        wr_clk,
  input  logic        wr_busy,
  input  logic        rd_cs,
  input  logic        rd_mosi,
  input  logic        rd_clk,
  input  logic        rd_busy,
  input  logic        wr_req,
  input  logic [31:0] wr_req_addr,
  input  logic        rd_req,
  input  logic [31:0] rd_req_addr,
  output logic        wr_start_en,
  output logic        rd_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [31:0] rd_sec_addr,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic        wr_err,
  output logic        rd_err,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic        sd_clk
);

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_START_WR,
    ST_HI_WR,
    ST_LO_WR,
    ST_START_RD,
    ST_HI_RD,
    ST_LO_RD,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    OWN_INIT,
    OWN_WR,
    OWN_RD,
    OWN_NONE
  } owner_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t     state;
  state_t     state_next;
  owner_t     owner;
  owner_t     owner_next;
  logic [7:0] gap_cnt;
  logic       last_wr;
  logic       wr_to;
  logic       rd_to;

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] to_cnt;
`else
  logic [47:0] unused_timeout_params;
  assign unused_timeout_params = {START_TO, BUSY_TO};
`endif

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state <= ST_INIT;
      owner <= OWN_INIT;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  always_comb begin
    state_next  = state;
    owner_next  = OWN_NONE;
    wr_start_en = 1'b0;
    rd_start_en = 1'b0;
    wr_ack      = 1'b0;
    rd_ack      = 1'b0;
    wr_to       = 1'b0;
    rd_to       = 1'b0;

    case (state)
      ST_INIT: begin
        if (init_done) state_next = ST_GAP;
      end
      ST_IDLE: begin
        // On a tie, last_wr=1 hands the grant to the read side.
        if (!init_done)                     state_next = ST_INIT;
        else if (wr_req && (!rd_req || !last_wr)) state_next = ST_START_WR;
        else if (rd_req)                    state_next = ST_START_RD;
      end
      ST_START_WR: begin
        wr_start_en = 1'b1;
        wr_ack      = 1'b1;
        state_next  = ST_HI_WR;
      end
      ST_HI_WR: begin
        if (wr_busy) state_next = ST_LO_WR;
`ifdef SD_ARB_TIMEOUT_EN
        else if (to_cnt == START_TO - 24'd1) begin
          wr_to      = 1'b1;
          state_next = ST_GAP;
        end
`endif
      end
      ST_LO_WR: begin
        if (!wr_busy) state_next = ST_GAP;
`ifdef SD_ARB_TIMEOUT_EN
        else if (to_cnt == BUSY_TO - 24'd1) begin
          wr_to      = 1'b1;
          state_next = ST_GAP;
        end
`endif
      end
      ST_START_RD: begin
        rd_start_en = 1'b1;
        rd_ack      = 1'b1;
        state_next  = ST_HI_RD;
      end
      ST_HI_RD: begin
        if (rd_busy) state_next = ST_LO_RD;
`ifdef SD_ARB_TIMEOUT_EN
        else if (to_cnt == START_TO - 24'd1) begin
          rd_to      = 1'b1;
          state_next = ST_GAP;
        end
`endif
      end
      ST_LO_RD: begin
        if (!rd_busy) state_next = ST_GAP;
`ifdef SD_ARB_TIMEOUT_EN
        else if (to_cnt == BUSY_TO - 24'd1) begin
          rd_to      = 1'b1;
          state_next = ST_GAP;
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase

    // Owner is registered from the next state so the pins switch with the state itself.
    case (state_next)
      ST_INIT:                          owner_next = OWN_INIT;
      ST_START_WR, ST_HI_WR, ST_LO_WR:  owner_next = OWN_WR;
      ST_START_RD, ST_HI_RD, ST_LO_RD:  owner_next = OWN_RD;
      default:                          owner_next = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      wr_sec_addr <= '0;
      rd_sec_addr <= '0;
      last_wr     <= 1'b0;
    end else if (state == ST_IDLE && state_next == ST_START_WR) begin
      wr_sec_addr <= wr_req_addr;
      last_wr     <= 1'b1;
    end else if (state == ST_IDLE && state_next == ST_START_RD) begin
      rd_sec_addr <= rd_req_addr;
      last_wr     <= 1'b0;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n || state != ST_GAP) gap_cnt <= '0;
    else                           gap_cnt <= gap_cnt + 8'd1;
  end

`ifdef SD_ARB_TIMEOUT_EN
  always_ff @(posedge clk_ref) begin
    if (!rst_n || state_next != state) to_cnt <= '0;
    else                               to_cnt <= to_cnt + 24'd1;
  end
`endif

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_err <= wr_to;
      rd_err <= rd_to;
    end
  end

  always_comb begin
    sd_cs   = 1'b1;
    sd_mosi = 1'b1;
    sd_clk  = 1'b0;
    case (owner)
      OWN_INIT: begin
        sd_cs   = init_cs;
        sd_mosi = init_mosi;
        sd_clk  = init_clk;
      end
      OWN_WR: begin
        sd_cs   = wr_cs;
        sd_mosi = wr_mosi;
        sd_clk  = wr_clk;
      end
      OWN_RD: begin
        sd_cs   = rd_cs;
        sd_mosi = rd_mosi;
        sd_clk  = rd_clk;
      end
      default: begin
        sd_cs   = 1'b1;
        sd_mosi = 1'b1;
        sd_clk  = 1'b0;
      end
    endcase
  end

endmodule
